// File: rtl/vga_pkg.sv
// Shared VGA chain types and default 640x480@60 timing.
package vga_pkg;
  localparam int PXL_X_W = 10;
  localparam int PXL_Y_W = 10;

  localparam int WIDTH_DEF  = 640;
  localparam int HEIGHT_DEF = 480;
  localparam int H_FP_DEF   = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF   = 48;
  localparam int V_FP_DEF   = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF   = 33;

  typedef struct packed {
    logic [PXL_X_W-1:0] pxl_x;
    logic [PXL_Y_W-1:0] pxl_y;
    logic [3:0]         red;
    logic [3:0]         green;
    logic [3:0]         blue;
    logic               hsync;
    logic               vsync;
    logic               active;
  } vga_t;
endpackage

// File: rtl/vga_if.sv
// Pixel chain interface passed from stage to stage.
interface vga;
  import vga_pkg::*;
  vga_t data;
  modport out (output data);
  modport in  (input  data);
endinterface

// File: rtl/timing_counter.sv
// Generic wrap counter; nxt is the value the counter holds after this edge.
module timing_counter #(
  parameter int MAX     = 799,
  parameter int RST_VAL = 799,
  parameter int W       = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] nxt,
  output logic         tc
);
  logic [W-1:0] cnt;

  assign tc = (cnt == W'(MAX));

  always_comb begin
    nxt = cnt;
    if (en) nxt = tc ? '0 : cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= W'(RST_VAL);
    else     cnt <= nxt;
endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters, sync and blanking at the head of the VGA chain.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int HEIGHT  = HEIGHT_DEF,
  parameter int H_FP    = H_FP_DEF,
  parameter int H_SYNC  = H_SYNC_DEF,
  parameter int H_BP    = H_BP_DEF,
  parameter int V_FP    = V_FP_DEF,
  parameter int V_SYNC  = V_SYNC_DEF,
  parameter int V_BP    = V_BP_DEF,
  parameter int FRAME_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_en,
  vga.out                    vga_chain_out,
  output logic               sof,
  output logic               eol,
  output logic [FRAME_W-1:0] frame_cnt
);
  localparam int H_TOTAL  = WIDTH + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = HEIGHT + V_FP + V_SYNC + V_BP;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int HS_START = WIDTH + H_FP;
  localparam int HS_END   = WIDTH + H_FP + H_SYNC;
  localparam int VS_START = HEIGHT + V_FP;
  localparam int VS_END   = HEIGHT + V_FP + V_SYNC;

  logic [HW-1:0] h_nxt;
  logic [VW-1:0] v_nxt;
  logic          h_tc, v_tc;
  vga_t          q;

  // Reset parks both counters on their last value so the first enabled edge lands on (0,0).
  timing_counter #(.MAX(H_TOTAL-1), .RST_VAL(H_TOTAL-1), .W(HW)) u_h (
    .clk(clk), .rst(reset), .en(pix_en), .nxt(h_nxt), .tc(h_tc)
  );

  timing_counter #(.MAX(V_TOTAL-1), .RST_VAL(V_TOTAL-1), .W(VW)) u_v (
    .clk(clk), .rst(reset), .en(pix_en && h_tc), .nxt(v_nxt), .tc(v_tc)
  );

  // Outputs are decoded from the post-edge counter values so they line up with the counters.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      q         <= '0;
      q.pxl_x   <= PXL_X_W'(H_TOTAL-1);
      q.pxl_y   <= PXL_Y_W'(V_TOTAL-1);
      q.hsync   <= 1'b1;
      q.vsync   <= 1'b1;
      sof       <= 1'b0;
      eol       <= 1'b0;
      frame_cnt <= '0;
    end else if (pix_en) begin
      q.pxl_x   <= PXL_X_W'(h_nxt);
      q.pxl_y   <= PXL_Y_W'(v_nxt);
      q.red     <= '0;
      q.green   <= '0;
      q.blue    <= '0;
      q.active  <= (int'(h_nxt) < WIDTH) && (int'(v_nxt) < HEIGHT);
      q.hsync   <= !((int'(h_nxt) >= HS_START) && (int'(h_nxt) < HS_END));
      q.vsync   <= !((int'(v_nxt) >= VS_START) && (int'(v_nxt) < VS_END));
      sof       <= (h_nxt == '0) && (v_nxt == '0);
      eol       <= (h_nxt == HW'(H_TOTAL-1));
      frame_cnt <= frame_cnt + FRAME_W'(h_tc && v_tc);
    end

  assign vga_chain_out.data = q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench for vga_timing_gen with a small raster and a position-arithmetic reference model.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int W = 16, H = 8, HFP = 2, HS = 4, HBP = 3, VFP = 1, VS = 2, VBP = 2, FW = 2;
  localparam int HT = W + HFP + HS + HBP;  // 25
  localparam int VT = H + VFP + VS + VBP;  // 13
  localparam int FR = HT * VT;             // 325

  logic clk = 1'b0, reset = 1'b1, pix_en = 1'b0;
  logic sof, eol;
  logic [FW-1:0] frame_cnt;
  vga vif();

  vga_timing_gen #(.WIDTH(W), .HEIGHT(H), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
                   .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .FRAME_W(FW)) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .vga_chain_out(vif),
    .sof(sof), .eol(eol), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit started = 0;
  longint mn = 0;  // enabled edges since last reset

  always @(posedge clk or posedge reset)
    if (reset) mn <= 0;
    else if (pix_en) mn <= mn + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Raster position after n enabled edges; n==0 is the parked reset position.
  function automatic void model(input longint n, output int x, output int y, output int f);
    longint l;
    if (n == 0) begin x = HT-1; y = VT-1; f = 0; end
    else begin
      l = n - 1;
      x = int'(l % HT);
      y = int'((l / HT) % VT);
      f = int'(((l / FR) + 1) % (1 << FW));
    end
  endfunction

  always @(negedge clk) if (started) begin
    int x, y, f;
    vga_t d;
    d = vif.data;
    model(mn, x, y, f);
    chk("pxl_x", int'(d.pxl_x), x);
    chk("pxl_y", int'(d.pxl_y), y);
    chk("frame_cnt", int'(frame_cnt), f);
    chk("active", int'(d.active), (mn != 0 && x < W && y < H) ? 1 : 0);
    chk("hsync", int'(d.hsync), (mn != 0 && x >= W+HFP && x < W+HFP+HS) ? 0 : 1);
    chk("vsync", int'(d.vsync), (mn != 0 && y >= H+VFP && y < H+VFP+VS) ? 0 : 1);
    chk("sof", int'(sof), (mn != 0 && x == 0 && y == 0) ? 1 : 0);
    chk("eol", int'(eol), (mn != 0 && x == HT-1) ? 1 : 0);
    chk("rgb", int'({d.red, d.green, d.blue}), 0);
  end

  initial begin
    int n_act, n_hs, n_vs, n_sof, x, y, f;
    bit hit;
    int frames[$];

    started = 1;
    repeat (3) @(posedge clk);
    @(posedge clk); #2 reset = 0; pix_en = 1;
    @(posedge clk); @(negedge clk);
    chk("first_x", int'(vif.data.pxl_x), 0);
    chk("first_y", int'(vif.data.pxl_y), 0);
    chk("first_sof", int'(sof), 1);
    chk("first_active", int'(vif.data.active), 1);
    chk("first_frame", int'(frame_cnt), 1);

    // One full frame with pix_en held high.
    n_act = 0; n_hs = 0; n_vs = 0; n_sof = 0;
    for (int i = 0; i < FR; i++) begin
      n_act += int'(vif.data.active);
      n_hs  += int'(!vif.data.hsync);
      n_vs  += int'(!vif.data.vsync);
      n_sof += int'(sof);
      @(negedge clk);
    end
    chk("frame_active_cnt", n_act, W*H);
    chk("frame_hsync_low", n_hs, HS*VT);
    chk("frame_vsync_low", n_vs, VS*HT);
    chk("frame_sof_cnt", n_sof, 1);
    chk("second_sof", int'(sof), 1);
    chk("second_frame", int'(frame_cnt), 2);

    // Alternating, then random, pixel enable.
    for (int i = 0; i < 300; i++) begin @(posedge clk); #2 pix_en = ~pix_en; end
    for (int i = 0; i < 1000; i++) begin @(posedge clk); #2 pix_en = 1'($urandom_range(0, 1)); end

    // Reset while both syncs are low.
    @(posedge clk); #2 pix_en = 1;
    hit = 0;
    for (int i = 0; i < FR + 5 && !hit; i++) begin
      @(negedge clk);
      model(mn, x, y, f);
      hit = (x == W+HFP+1) && (y == H+VFP+1);
    end
    chk("sync_target_hit", int'(hit), 1);
    chk("pre_reset_hsync", int'(vif.data.hsync), 0);
    chk("pre_reset_vsync", int'(vif.data.vsync), 0);
    #1 reset = 1;
    #1;
    chk("rst_hsync", int'(vif.data.hsync), 1);
    chk("rst_vsync", int'(vif.data.vsync), 1);
    chk("rst_active", int'(vif.data.active), 0);
    chk("rst_x", int'(vif.data.pxl_x), HT-1);
    chk("rst_y", int'(vif.data.pxl_y), VT-1);
    chk("rst_frame", int'(frame_cnt), 0);
    repeat (2) @(posedge clk);
    #2 reset = 0;
    @(posedge clk); @(negedge clk);

    // Five frames: frame counter wraps through 1,2,3,0,1.
    for (int i = 0; i < 5*FR; i++) begin
      if (sof) frames.push_back(int'(frame_cnt));
      @(negedge clk);
    end
    chk("wrap_sof_cnt", frames.size(), 5);
    for (int i = 0; i < 5 && i < frames.size(); i++)
      chk($sformatf("wrap_frame%0d", i), frames[i], (i + 1) % 4);

    // Random async reset pulses under random enable.
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(20, 200)) begin @(posedge clk); #2 pix_en = 1'($urandom_range(0, 1)); end
      #($urandom_range(1, 7)) reset = 1;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #2 reset = 0;
    end
    repeat (50) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
